// File: rtl/counter_seq_ctrl.sv
// Sequencing controller around a WIDTH-bit up counter: configurable period / one-shot timer
// with valid/ready configuration, start/hold/abort control, tick pulse and done flag.
module counter_seq_ctrl #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_reload,
   input  logic             start,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tick,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_q, w_q_d;
   logic [WIDTH-1:0] r_limit, w_limit_d;
   logic             r_reload, w_reload_d;
   logic             r_tick, w_tick_d;
   logic             w_cfg_hs;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_q      <= '0;
         r_limit  <= '0;
         r_reload <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_q      <= w_q_d;
         r_limit  <= w_limit_d;
         r_reload <= w_reload_d;
         r_tick   <= w_tick_d;
      end
   end

   // Ready comes from the state register alone, so the handshake never loops through inputs.
   assign w_cfg_hs = cfg_valid && (r_state != StRun);

   always_comb begin
      w_state_d  = r_state;
      w_q_d      = r_q;
      w_limit_d  = r_limit;
      w_reload_d = r_reload;
      w_tick_d   = 1'b0;
      if (abort) begin
         w_state_d = StIdle;
         w_q_d     = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_q_d = '0;
               if (w_cfg_hs) begin
                  w_limit_d  = cfg_limit;
                  w_reload_d = cfg_reload;
                  w_state_d  = StArmed;
               end
            end
            StArmed: begin
               w_q_d = '0;
               if (w_cfg_hs) begin
                  w_limit_d  = cfg_limit;
                  w_reload_d = cfg_reload;
               end else if (start) begin
                  w_state_d = StRun;
               end
            end
            StRun: begin
               if (!hold) begin
                  if (r_q == r_limit) begin
                     w_tick_d = 1'b1;
                     if (r_reload) begin
                        w_q_d = '0;
                     end else begin
                        w_state_d = StDone;
                     end
                  end else begin
                     w_q_d = r_q + WIDTH'(1);
                  end
               end
            end
            StDone: begin
               if (w_cfg_hs) begin
                  w_limit_d  = cfg_limit;
                  w_reload_d = cfg_reload;
                  w_q_d      = '0;
                  w_state_d  = StArmed;
               end else if (start) begin
                  w_q_d     = '0;
                  w_state_d = StRun;
               end
            end
            default: begin
               w_state_d = StIdle;
               w_q_d     = '0;
            end
         endcase
      end
   end

   always_comb begin
      cfg_ready = (r_state != StRun);
      busy      = (r_state == StRun);
      done      = (r_state == StDone);
      q         = r_q;
      tick      = r_tick;
   end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller wrapped around a WIDTH-bit up counter; it turns the free-running counter into a programmable period or one-shot timer. It accepts a configuration (terminal value and mode) over a valid/ready handshake, then starts, holds, aborts and restarts the count. It reports terminal events as a one-cycle tick pulse and one-shot completion as a done flag. Other blocks use it as the shared time-base / interval timer.

Parameters:
WIDTH, 3, counter width in bits; also the width of cfg_limit and q.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  controller accepts configuration this cycle
cfg_limit  input  WIDTH  terminal count; period = cfg_limit+1 cycles
cfg_reload  input  1  1 = auto-reload (periodic), 0 = one-shot
start  input  1  begin counting (level sampled each cycle)
hold  input  1  freeze count while high (RUN only)
abort  input  1  return to IDLE from any state
q  output  WIDTH  current count value (registered)
busy  output  1  state is RUN (registered)
tick  output  1  one-cycle pulse following each terminal event (registered)
done  output  1  high while in DONE (registered)

Behaviour:
- Reset (sync, highest priority): state=IDLE; q=0; tick=0; done=0; busy=0; stored limit=0, reload=0. Reset mid-run takes effect at the next edge with no tick.
- Input priority per cycle: reset > abort > cfg handshake > start > hold.
- States: IDLE, ARMED, RUN, DONE. cfg_ready = 1 in IDLE, ARMED, DONE; 0 in RUN. cfg_ready is decoded from the state register only, not from cfg_valid.
- IDLE: q=0. On cfg_valid&cfg_ready, latch limit/reload and go to ARMED. start is ignored in IDLE.
- ARMED: q=0. A new cfg handshake overwrites the stored config and stays in ARMED. If start=1 and there is no handshake, go to RUN; q is still 0 in the first RUN cycle.
- RUN, hold=1: q frozen, no terminal event, state unchanged.
- RUN, hold=0, q != limit: q <= q+1.
- RUN, hold=0, q == limit (terminal event): tick <= 1 for the next cycle.
  - reload=1: q <= 0, stay in RUN.
  - reload=0: go to DONE, q holds limit.
- limit=0: reload gives tick every cycle in RUN with q stuck at 0; one-shot reaches DONE after one RUN cycle.
- DONE: done=1, q=limit.
  - start=1: q <= 0, return to RUN with the same config; done falls next cycle.
  - cfg handshake: latch new config, q <= 0, go to ARMED. A handshake takes priority over start.
- abort: next state IDLE, q <= 0, tick <= 0. Stored config is retained but must be re-offered to leave IDLE.
- Arithmetic: q never exceeds limit. With limit = 2^WIDTH-1, q wraps 111..1 -> 0, same as the plain counter. Increment is modulo 2^WIDTH.
- tick is never asserted for two consecutive cycles except when limit=0 with reload=1.
- hold is ignored outside RUN. start held high in RUN has no effect.
- All outputs come directly from flops or are decoded from the state register only; no input-to-output combinational path.

Test Plan:
- Reset then cfg limit=7, reload=1, start -> q counts 0..7,0..; tick high in the cycle after each q=7, period 8. Continue 24 cycles -> 3 ticks.
- cfg limit=5, reload=0, start -> q 0,1,2,3,4,5. Next cycle: tick=1, done=1, q=5; then tick=0, done stays 1. start in DONE -> q=0, busy=1, done=0 next cycle.
- limit=5, reload=1; assert hold for 3 cycles at q=2 -> q stays 2 for 3 cycles, resumes at 3, tick delayed by 3 cycles. hold while q=5 -> no tick until released.
- abort at q=4 in RUN -> next cycle IDLE, q=0, busy=0, tick=0. start alone then does nothing. cfg_valid with cfg_ready=0 during RUN -> not accepted, limit unchanged.
- limit=0, reload=1 -> tick every cycle, q=0. limit=0, reload=0 -> one RUN cycle, then tick=1, done=1.
- reset asserted mid-RUN at q=3 together with start and cfg_valid -> next cycle all outputs 0, state IDLE, cfg_ready=1.
